// File: rtl/snake_pkg.sv
// Shared types and constants for the snake animation sequencer.
package snake_pkg;

   typedef enum logic [1:0] {
      CMD_RUN        = 2'd0,
      CMD_PAUSE      = 2'd1,
      CMD_STEP       = 2'd2,
      CMD_LOAD_SPEED = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_STEP  = 2'd3
   } seq_state_e;

   localparam int         SNAKE_ITER_N = 13;
   localparam logic [6:0] SEG_BLANK    = 7'b1111111;

endpackage

// File: rtl/snake_sequencer_tick_prescaler.sv
// Ticks-per-phase prescaler: owns the speed register and the tick counter.
// A speed of zero is stored as one so the counter always has a terminal value.
module tick_prescaler #(
   parameter int TICKS_W       = 16,
   parameter int DEFAULT_TICKS = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               clear,
   input  logic               load,
   input  logic [TICKS_W-1:0] speed,
   output logic               tc
);

   logic [TICKS_W-1:0] speed_r;
   logic [TICKS_W-1:0] count_r;
   logic [TICKS_W-1:0] last_s;

   function automatic logic [TICKS_W-1:0] clamp_speed(input logic [TICKS_W-1:0] s);
      return (s == {TICKS_W{1'b0}}) ? TICKS_W'(1) : s;
   endfunction

   assign last_s = speed_r - TICKS_W'(1);
   assign tc     = enable && (count_r == last_s);

   // Speed register, reloaded by LOAD_SPEED
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed_r <= clamp_speed(TICKS_W'(DEFAULT_TICKS));
      end else if (load) begin
         speed_r <= clamp_speed(speed);
      end else begin
         speed_r <= speed_r;
      end
   end

   // Tick counter: clear wins, otherwise count 0..speed-1 while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {TICKS_W{1'b0}};
      end else if (clear) begin
         count_r <= {TICKS_W{1'b0}};
      end else if (enable) begin
         count_r <= tc ? {TICKS_W{1'b0}} : (count_r + TICKS_W'(1));
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/snake_sequencer.sv
// Command-driven phase sequencer for the two-digit snake animation.
// Define SNAKE_SEQ_REVERSE_EN to honour `dir`; otherwise every advance is forward.
module snake_sequencer
   import snake_pkg::*;
#(
   parameter int ITER_N        = SNAKE_ITER_N,
   parameter int TICKS_W       = 16,
   parameter int DEFAULT_TICKS = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [TICKS_W-1:0]        cmd_data,
   input  logic                      dir,
   output logic [$clog2(ITER_N)-1:0] phase,
   output logic                      phase_stb,
   output logic                      running,
   output logic                      blank
);

   localparam int                 PHASE_W    = $clog2(ITER_N);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(ITER_N - 1);
   localparam logic [PHASE_W-1:0] PHASE_ZERO = {PHASE_W{1'b0}};

   seq_state_e         state_r;
   seq_state_e         state_nx_s;
   cmd_op_e            op_s;
   logic               accept_s;
   logic               tick_en_s;
   logic               tick_clr_s;
   logic               tick_load_s;
   logic               tick_tc_s;
   logic               step_adv_s;
   logic               advance_s;
   logic [PHASE_W-1:0] phase_nx_s;
   logic               stb_nx_s;
   logic               running_nx_s;
   logic               blank_nx_s;
   logic               ready_nx_s;

`ifdef SNAKE_SEQ_REVERSE_EN
   function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p,
                                                     input logic rev);
      if (rev) begin
         return (p == PHASE_ZERO) ? PHASE_LAST : (p - PHASE_W'(1));
      end else begin
         return (p == PHASE_LAST) ? PHASE_ZERO : (p + PHASE_W'(1));
      end
   endfunction
`else
   logic unused_dir_s;
   assign unused_dir_s = dir;

   function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
      return (p == PHASE_LAST) ? PHASE_ZERO : (p + PHASE_W'(1));
   endfunction
`endif

   assign op_s     = cmd_op_e'(cmd_op);
   assign accept_s = cmd_valid && cmd_ready;

   // PAUSE and LOAD_SPEED freeze the counter, which also suppresses a coincident terminal tick
   assign tick_load_s = accept_s && (op_s == CMD_LOAD_SPEED);
   assign tick_clr_s  = tick_load_s || (accept_s && (op_s == CMD_RUN) && (state_r != ST_RUN));
   assign tick_en_s   = (state_r == ST_RUN) &&
                        !(accept_s && ((op_s == CMD_PAUSE) || (op_s == CMD_LOAD_SPEED)));
   assign step_adv_s  = accept_s && (op_s == CMD_STEP) &&
                        ((state_r == ST_IDLE) || (state_r == ST_PAUSE));
   assign advance_s   = tick_tc_s || step_adv_s;

   tick_prescaler #(
      .TICKS_W       (TICKS_W),
      .DEFAULT_TICKS (DEFAULT_TICKS)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .enable (tick_en_s),
      .clear  (tick_clr_s),
      .load   (tick_load_s),
      .speed  (cmd_data),
      .tc     (tick_tc_s)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE, ST_PAUSE: begin
            if (accept_s) begin
               case (op_s)
                  CMD_RUN:   state_nx_s = ST_RUN;
                  CMD_PAUSE: state_nx_s = ST_PAUSE;
                  CMD_STEP:  state_nx_s = ST_STEP;
                  default:   state_nx_s = state_r;
               endcase
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_RUN: begin
            if (accept_s && (op_s == CMD_PAUSE)) begin
               state_nx_s = ST_PAUSE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_STEP: state_nx_s = ST_PAUSE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Output next values, derived from the state being entered
   always_comb begin
      phase_nx_s = phase;
      if (advance_s) begin
`ifdef SNAKE_SEQ_REVERSE_EN
         phase_nx_s = next_phase(phase, dir);
`else
         phase_nx_s = next_phase(phase);
`endif
      end else begin
         phase_nx_s = phase;
      end
      stb_nx_s     = advance_s;
      running_nx_s = (state_nx_s == ST_RUN);
      blank_nx_s   = (state_nx_s == ST_IDLE);
      ready_nx_s   = (state_nx_s != ST_STEP);
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase     <= PHASE_ZERO;
         phase_stb <= 1'b0;
         running   <= 1'b0;
         blank     <= 1'b1;
         cmd_ready <= 1'b1;
      end else begin
         phase     <= phase_nx_s;
         phase_stb <= stb_nx_s;
         running   <= running_nx_s;
         blank     <= blank_nx_s;
         cmd_ready <= ready_nx_s;
      end
   end

endmodule

// File: doc/snake_sequencer.md
# snake_sequencer

Command-driven sequencer for the two-digit snake animation on the 7-segment displays. It owns the animation's timing and phase counter: a programmable tick prescaler, run/pause/single-step control, direction selection and display blanking. Its `phase` output indexes the downstream pattern decoder that drives `display1`/`display2`. Commands arrive over a valid/ready handshake from the board-level control logic (buttons, switches or a host).

## Interface
Parameters:
- `ITER_N`, 13: number of animation phases; `phase` counts modulo `ITER_N`.
- `TICKS_W`, 16: width of the speed (ticks-per-phase) register.
- `DEFAULT_TICKS`, 10: ticks per phase loaded at reset.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 2: 0 RUN, 1 PAUSE, 2 STEP, 3 LOAD_SPEED.
- `cmd_data` in `TICKS_W`: ticks-per-phase operand, used by LOAD_SPEED only.
- `dir` in 1: 0 forward, 1 reverse; sampled at every advance.
- `phase` out `$clog2(ITER_N)`: current phase index, 0..`ITER_N`-1.
- `phase_stb` out 1: one-cycle pulse in the first cycle `phase` shows a new value.
- `running` out 1: high in RUN state.
- `blank` out 1: high in IDLE state; the decoder forces all segments off (7'b1111111).

## Operation
- States: IDLE, RUN, PAUSE, STEP.
- Reset (async) values: state IDLE, `phase`=0, `phase_stb`=0, `running`=0, `blank`=1, `cmd_ready`=1, tick counter 0, speed register `DEFAULT_TICKS`.
- A command is accepted on a rising edge where `cmd_valid`&&`cmd_ready`.
- `cmd_ready` is 1 in every state except STEP.
- RUN: from IDLE or PAUSE, clears the tick counter and enters RUN. In RUN it is a no-op and the counter is not cleared.
- PAUSE: from RUN, enters PAUSE and the tick counter holds its value. From IDLE, enters PAUSE and `blank` drops. In PAUSE it is a no-op.
- STEP: from IDLE or PAUSE, enters STEP, advances `phase` once and pulses `phase_stb`. The next cycle is unconditionally PAUSE. In RUN it is accepted and ignored.
- LOAD_SPEED: loads the speed register (`cmd_data`=0 is stored as 1) and clears the tick counter. It is legal in any state and does not change state.
- Tick counter: counts 0..speed-1 only in RUN. At terminal value speed-1 it wraps to 0 and advances `phase`.
- Advance: forward goes `ITER_N`-1→0, otherwise +1. Reverse goes 0→`ITER_N`-1, otherwise −1.
- An accepted command in the same cycle as a terminal tick takes priority:
  - PAUSE or LOAD_SPEED suppresses the advance.
  - RUN in RUN does not suppress it.
- Reset mid-operation returns immediately to the reset values; no partial advance is visible.

## Timing
- `phase`, `phase_stb`, `running`, `blank` and `cmd_ready` are all registered outputs.
- RUN accepted at edge t: `running`=1 at t+1. The first `phase` change and `phase_stb` occur at edge t+speed, then every speed cycles.
- With speed=1, `phase` advances every cycle and `phase_stb` stays high continuously.
- STEP accepted at edge t:
  - at t+1: `phase` updated, `phase_stb`=1, `cmd_ready`=0;
  - at t+2: state PAUSE, `cmd_ready`=1, `phase_stb`=0.
- `cmd_valid` held across the STEP cycle is accepted at t+2 at the earliest.
- Resuming from PAUSE with RUN restarts the tick count from 0. The remainder of the interrupted period is discarded.

## Configuration
- `SNAKE_SEQ_REVERSE_EN` defined: `dir` is honoured as described.
- `SNAKE_SEQ_REVERSE_EN` undefined: `dir` is still present but ignored, and every advance is forward. No reverse-wrap logic is synthesised.

## Structure
- Package `snake_pkg`:
  - `cmd_op_e` enum (RUN, PAUSE, STEP, LOAD_SPEED);
  - `seq_state_e` enum (IDLE, RUN, PAUSE, STEP);
  - constants `SNAKE_ITER_N`=13 and `SEG_BLANK`=7'b1111111.
- Sub-module `tick_prescaler`:
  - inputs: enable, clear, speed;
  - output: terminal-count pulse;
  - owns the tick counter and the zero→1 clamp.
- The phase counter and FSM live in `snake_sequencer`.

## Test plan
- Reset then idle 20 cycles: `blank`=1, `phase`=0, no `phase_stb`. LOAD_SPEED 3 then RUN, forward: `phase` 0→1→2 at 3-cycle spacing.
- RUN at speed 10 for 13 advances: `phase` wraps 12→0 on the 13th `phase_stb`. With `dir`=1 from phase 0: next `phase`=12 (macro defined); next `phase`=1 (macro undefined).
- PAUSE at tick 6 of 10, hold 50 cycles, then RUN: no advance while paused, next advance exactly 10 cycles after RUN is accepted.
- Two STEPs back-to-back from PAUSE with `cmd_valid` held: `phase` +1, +1, `cmd_ready` low one cycle per step, `running` stays 0.
- PAUSE presented in the terminal-tick cycle: `phase` unchanged. LOAD_SPEED 0 followed by RUN: `phase` advances every cycle.
- Assert `rst` mid-RUN at `phase`=7: `phase`=0, `blank`=1 and speed back to 10, all asynchronously, before the next clock edge.
